// File: rtl/fft_pkg.sv
// Shared definitions for the FFT datapath: width helpers, bit reversal,
// result-FIFO sizing and the unloader state encoding.
package fft_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } unload_state_t;

    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int b = 0; b < 31; b++) begin
            if ((1 << b) < value) begin
                r = b + 1;
            end
        end
        return r;
    endfunction

    function automatic int addr_width(input int n);
        return (log2(n) < 1) ? 1 : log2(n);
    endfunction

    function automatic int data_width(input int int_bits, input int frac_bits);
        return int_bits + frac_bits;
    endfunction

    // Mirrors the low 'width' bits of value; bits above width come back as 0.
    function automatic logic [31:0] bitrev(input logic [31:0] value, input int width);
        logic [31:0] r;
        r = '0;
        for (int b = 0; b < 32; b++) begin
            if (b < width) begin
                r = r | (((value >> (width - 1 - b)) & 32'd1) << b);
            end
        end
        return r;
    endfunction

    localparam int FIFO_DEPTH   = 4;
    localparam int FIFO_COUNT_W = log2(FIFO_DEPTH) + 1;

endpackage

// File: rtl/fft_result_fifo.sv
// Small first-word-fall-through FIFO holding captured results; the head entry
// is visible combinationally so the stream can present it without extra latency.
module fft_result_fifo
    import fft_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = FIFO_DEPTH,
    localparam int PTR_W = log2(DEPTH),
    localparam int COUNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   head_data,
    output logic [COUNT_W-1:0] count,
    output logic               empty,
    output logic               full
);

    logic [WIDTH-1:0]   mem_reg [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [COUNT_W-1:0] count_reg;
    logic               push_ok;
    logic               pop_ok;

    assign empty     = (count_reg == '0);
    assign full      = (count_reg == COUNT_W'(DEPTH));
    assign pop_ok    = pop && !empty;
    assign push_ok   = push && (!full || pop_ok);
    assign count     = count_reg;
    assign head_data = mem_reg[rd_ptr_reg];

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_reg == PTR_W'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(push_ok);
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(pop_ok);
            count_reg  <= count_reg + COUNT_W'(push_ok) - COUNT_W'(pop_ok);
        end
    end

endmodule

// File: rtl/fft_unload.sv
// Reads the N FFT results out of the selected RAM bank and streams them out
// in natural or bit-reversed order, buffering RAM read latency in a small FIFO.
module fft_unload
    import fft_pkg::*;
#(
    parameter int N = 8,
    parameter int I = 4,
    parameter int F = 4,
    localparam int ADDR_W = addr_width(N),
    localparam int DATA_W = data_width(I, F)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic              i_bank,
    input  logic              i_bitrev,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_bank_sel,
    output logic              o_even_odd_sel,
    input  logic [DATA_W-1:0] i_rd_data_re,
    input  logic [DATA_W-1:0] i_rd_data_im,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data_re,
    output logic [DATA_W-1:0] o_data_im,
    output logic [ADDR_W-1:0] o_index,
    output logic              o_last,
    output logic              o_busy,
    output logic              o_done
);

    localparam int FIFO_W = 2 * DATA_W + ADDR_W;
    localparam logic [ADDR_W:0]         CNT_LAST   = (ADDR_W + 1)'(N - 1);
    localparam logic [ADDR_W-1:0]       IDX_LAST   = ADDR_W'(N - 1);
    localparam logic [FIFO_COUNT_W:0]   OCC_LIMIT  = (FIFO_COUNT_W + 1)'(FIFO_DEPTH);

    unload_state_t           state_reg;
    logic [ADDR_W:0]         rd_cnt_reg;
    logic                    inflight_reg;
    logic [ADDR_W-1:0]       inflight_idx_reg;
    logic                    bank_reg;
    logic                    bitrev_reg;

    logic                    start_accept;
    logic                    rd_en;
    logic                    pop;
    logic                    last_beat;
    logic                    fifo_empty;
    logic                    fifo_full;
    logic [FIFO_COUNT_W-1:0] fifo_count;
    logic [FIFO_COUNT_W:0]   occupancy;
    logic [FIFO_W-1:0]       head_data;
    logic [DATA_W-1:0]       head_re;
    logic [DATA_W-1:0]       head_im;
    logic [ADDR_W-1:0]       head_idx;

    assign start_accept = (state_reg == ST_IDLE) && i_start;

    // Outstanding reads include the one whose data lands this cycle; a pop in
    // the same cycle is deliberately not credited, keeping the check simple.
    assign occupancy = {1'b0, fifo_count} + {{FIFO_COUNT_W{1'b0}}, inflight_reg};
    assign rd_en     = (state_reg == ST_RUN) && (rd_cnt_reg <= CNT_LAST)
                       && !fifo_full && (occupancy < OCC_LIMIT);

    assign {head_re, head_im, head_idx} = head_data;

    assign pop       = !fifo_empty && i_ready;
    assign last_beat = !fifo_empty && (head_idx == IDX_LAST);

    assign o_rd_en        = rd_en;
    assign o_rd_addr      = !rd_en ? '0
                          : bitrev_reg ? ADDR_W'(bitrev(32'(rd_cnt_reg[ADDR_W-1:0]), ADDR_W))
                          : rd_cnt_reg[ADDR_W-1:0];
    assign o_bank_sel     = bank_reg;
    assign o_even_odd_sel = 1'b0;
    assign o_valid        = !fifo_empty;
    assign o_data_re      = fifo_empty ? '0 : head_re;
    assign o_data_im      = fifo_empty ? '0 : head_im;
    assign o_index        = fifo_empty ? '0 : head_idx;
    assign o_last         = last_beat;
    assign o_busy         = (state_reg != ST_IDLE);
    assign o_done         = (state_reg == ST_DONE);

    fft_result_fifo #(
        .WIDTH(FIFO_W),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .clr      (start_accept),
        .push     (inflight_reg),
        .pop      (pop),
        .push_data({i_rd_data_re, i_rd_data_im, inflight_idx_reg}),
        .head_data(head_data),
        .count    (fifo_count),
        .empty    (fifo_empty),
        .full     (fifo_full)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg        <= ST_IDLE;
            rd_cnt_reg       <= '0;
            inflight_reg     <= 1'b0;
            inflight_idx_reg <= '0;
            bank_reg         <= 1'b0;
            bitrev_reg       <= 1'b0;
        end else begin
            inflight_reg <= rd_en;
            if (rd_en) begin
                inflight_idx_reg <= rd_cnt_reg[ADDR_W-1:0];
                rd_cnt_reg       <= rd_cnt_reg + 1'b1;
            end
            case (state_reg)
                ST_IDLE: begin
                    if (i_start) begin
                        state_reg    <= ST_RUN;
                        bank_reg     <= i_bank;
                        bitrev_reg   <= i_bitrev;
                        rd_cnt_reg   <= '0;
                        inflight_reg <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (rd_en && (rd_cnt_reg == CNT_LAST)) begin
                        state_reg <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (pop && last_beat) begin
                        state_reg <= ST_DONE;
                    end
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_unload.sv
// Scoreboard bench for fft_unload: an N=8 instance for the main scenarios and
// an N=2 instance for the minimum-length case, each fed by a small RAM model.
module tb_fft_unload;

    localparam int N  = 8;
    localparam int N2 = 2;
    localparam int BR_SEQ [8] = '{0, 4, 2, 6, 1, 5, 3, 7};

    typedef struct packed {
        logic [7:0] re;
        logic [7:0] im;
        logic [31:0] idx;
    } beat_t;

    logic clk;
    logic rst;

    logic       i_start, i_bank, i_bitrev, i_ready;
    logic       o_rd_en, o_bank_sel, o_even_odd_sel, o_valid, o_last, o_busy, o_done;
    logic [2:0] o_rd_addr, o_index;
    logic [7:0] rd_re, rd_im, o_data_re, o_data_im;

    logic       start2, ready2;
    logic       rd_en2, bank_sel2, even_odd2, valid2, last2, busy2, done2;
    logic [0:0] rd_addr2, index2;
    logic [7:0] rd2_re, rd2_im, data2_re, data2_im;

    logic [7:0] ram_re  [2][8];
    logic [7:0] ram_im  [2][8];
    logic [7:0] ram2_re [2];
    logic [7:0] ram2_im [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int start_cyc = 0;

    beat_t exp_q [$];
    beat_t exp2_q [$];
    int    addr_log [$];
    int beats, first_rel, last_rel, done_cnt, done_rel, rd_pulses;
    int beats2, first2_rel, last2_rel, done2_cnt, done2_rel;
    logic       stall_prev;
    logic [7:0] prev_re, prev_im;
    logic [2:0] prev_idx;
    logic       prev_last;

    fft_unload #(.N(N), .I(4), .F(4)) u_dut (
        .clk(clk), .rst(rst), .i_start(i_start), .i_bank(i_bank), .i_bitrev(i_bitrev),
        .o_rd_en(o_rd_en), .o_rd_addr(o_rd_addr), .o_bank_sel(o_bank_sel),
        .o_even_odd_sel(o_even_odd_sel), .i_rd_data_re(rd_re), .i_rd_data_im(rd_im),
        .o_valid(o_valid), .i_ready(i_ready), .o_data_re(o_data_re), .o_data_im(o_data_im),
        .o_index(o_index), .o_last(o_last), .o_busy(o_busy), .o_done(o_done)
    );

    fft_unload #(.N(N2), .I(4), .F(4)) u_dut2 (
        .clk(clk), .rst(rst), .i_start(start2), .i_bank(1'b0), .i_bitrev(1'b0),
        .o_rd_en(rd_en2), .o_rd_addr(rd_addr2), .o_bank_sel(bank_sel2),
        .o_even_odd_sel(even_odd2), .i_rd_data_re(rd2_re), .i_rd_data_im(rd2_im),
        .o_valid(valid2), .i_ready(ready2), .o_data_re(data2_re), .o_data_im(data2_im),
        .o_index(index2), .o_last(last2), .o_busy(busy2), .o_done(done2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM model: one cycle registered read from the selected bank.
    always @(posedge clk) begin
        if (o_rd_en) begin
            rd_re <= ram_re[o_bank_sel][o_rd_addr];
            rd_im <= ram_im[o_bank_sel][o_rd_addr];
        end
        if (rd_en2) begin
            rd2_re <= ram2_re[rd_addr2];
            rd2_im <= ram2_im[rd_addr2];
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int tb_rev(input int v, input int w);
        int r = 0;
        for (int b = 0; b < w; b++) begin
            if ((v & (1 << b)) != 0) r = r | (1 << (w - 1 - b));
        end
        return r;
    endfunction

    task automatic clear_mon();
        exp_q.delete();
        exp2_q.delete();
        addr_log.delete();
        beats = 0; first_rel = -1; last_rel = -1; done_cnt = 0; done_rel = -1; rd_pulses = 0;
        beats2 = 0; first2_rel = -1; last2_rel = -1; done2_cnt = 0; done2_rel = -1;
        stall_prev = 1'b0;
    endtask

    task automatic sample();
        int rel;
        beat_t e;
        rel = cyc - start_cyc;
        if (o_rd_en) begin
            rd_pulses++;
            addr_log.push_back(int'(o_rd_addr));
        end
        if (o_done) begin
            done_cnt++;
            done_rel = rel;
        end
        if (o_valid) begin
            if (stall_prev) begin
                check("stall_re", 32'(o_data_re), 32'(prev_re));
                check("stall_im", 32'(o_data_im), 32'(prev_im));
                check("stall_idx", 32'(o_index), 32'(prev_idx));
                check("stall_last", 32'(o_last), 32'(prev_last));
            end
            if (i_ready) begin
                $display("beat t=%0d idx=%0d re=%02h im=%02h last=%0b",
                         rel, o_index, o_data_re, o_data_im, o_last);
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_re", 32'(o_data_re), 32'(e.re));
                    check("beat_im", 32'(o_data_im), 32'(e.im));
                    check("beat_idx", 32'(o_index), e.idx);
                    check("beat_last", 32'(o_last), 32'(e.idx == N - 1));
                end
                beats++;
                if (first_rel < 0) first_rel = rel;
                last_rel = rel;
            end
        end
        stall_prev = o_valid && !i_ready;
        prev_re = o_data_re; prev_im = o_data_im; prev_idx = o_index; prev_last = o_last;

        if (done2) begin
            done2_cnt++;
            done2_rel = rel;
        end
        if (valid2 && ready2) begin
            $display("n2 beat t=%0d idx=%0d re=%02h im=%02h last=%0b",
                     rel, index2, data2_re, data2_im, last2);
            if (exp2_q.size() == 0) begin
                check("n2_extra_beat", 32'd1, 32'd0);
            end else begin
                e = exp2_q.pop_front();
                check("n2_re", 32'(data2_re), 32'(e.re));
                check("n2_im", 32'(data2_im), 32'(e.im));
                check("n2_idx", 32'(index2), e.idx);
                check("n2_last", 32'(last2), 32'(e.idx == N2 - 1));
            end
            beats2++;
            if (first2_rel < 0) first2_rel = rel;
            last2_rel = rel;
        end
    endtask

    // Sample mid-cycle, then advance to just after the next rising edge.
    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic reset_check(input string tag);
        check({tag, "_valid"}, 32'(o_valid), 32'd0);
        check({tag, "_rd_en"}, 32'(o_rd_en), 32'd0);
        check({tag, "_rd_addr"}, 32'(o_rd_addr), 32'd0);
        check({tag, "_bank_sel"}, 32'(o_bank_sel), 32'd0);
        check({tag, "_last"}, 32'(o_last), 32'd0);
        check({tag, "_busy"}, 32'(o_busy), 32'd0);
        check({tag, "_done"}, 32'(o_done), 32'd0);
        check({tag, "_index"}, 32'(o_index), 32'd0);
        check({tag, "_data_re"}, 32'(o_data_re), 32'd0);
        check({tag, "_data_im"}, 32'(o_data_im), 32'd0);
        check({tag, "_even_odd"}, 32'(o_even_odd_sel), 32'd0);
    endtask

    task automatic push_expected(input logic bank, input logic br);
        int a;
        for (int k = 0; k < N; k++) begin
            a = br ? tb_rev(k, 3) : k;
            exp_q.push_back('{re: ram_re[bank][a], im: ram_im[bank][a], idx: 32'(k)});
        end
    endtask

    // mode 0: ready high; mode 1: ready toggles 1,0,...; mode 2: ready low until cycle 12
    task automatic run_unload(input logic bank, input logic br, input int mode);
        clear_mon();
        push_expected(bank, br);
        i_bank = bank; i_bitrev = br; i_start = 1'b1;
        i_ready = (mode == 0);
        start_cyc = cyc;
        step();
        for (int k = 1; k < 300 && done_cnt == 0; k++) begin
            i_start = 1'b0;
            case (mode)
                0: i_ready = 1'b1;
                1: i_ready = (k % 2 == 1);
                default: begin
                    if (k == 12) begin
                        check("hold_rd_pulses", 32'(rd_pulses), 32'd4);
                        check("hold_rd_en_low", 32'(o_rd_en), 32'd0);
                    end
                    i_ready = (k >= 12);
                end
            endcase
            step();
        end
        if (done_cnt == 0) check("timeout_done", 32'd0, 32'd1);
        check("beats", 32'(beats), 32'(N));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("rd_pulses", 32'(rd_pulses), 32'(N));
        check("done_pulse_width", 32'(o_done), 32'd0);
        check("busy_after", 32'(o_busy), 32'd0);
        check("bank_sel", 32'(o_bank_sel), 32'(bank));
        if (mode == 0) begin
            check("first_beat_cycle", 32'(first_rel), 32'd3);
            check("last_beat_cycle", 32'(last_rel), 32'(N + 2));
            check("done_cycle", 32'(done_rel), 32'(N + 3));
        end
        if (br) begin
            for (int k = 0; k < N; k++) begin
                check("bitrev_addr", 32'(addr_log[k]), 32'(BR_SEQ[k]));
            end
        end
    endtask

    initial begin
        rst = 1'b1; i_start = 1'b0; i_bank = 1'b1; i_bitrev = 1'b0; i_ready = 1'b0;
        start2 = 1'b0; ready2 = 1'b0;
        for (int k = 0; k < 8; k++) begin
            ram_re[0][k] = 8'(k * 16);
            ram_im[0][k] = 8'(-k);
            ram_re[1][k] = 8'(8'hA0 + k);
            ram_im[1][k] = 8'(8'h30 + 3 * k);
        end
        ram2_re[0] = 8'h5A; ram2_im[0] = 8'hC3;
        ram2_re[1] = 8'h96; ram2_im[1] = 8'h0F;
        clear_mon();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        reset_check("reset");
        check("n2_reset_valid", 32'(valid2), 32'd0);
        check("n2_reset_even_odd", 32'(even_odd2), 32'd0);

        run_unload(1'b0, 1'b0, 0);
        run_unload(1'b0, 1'b1, 0);
        run_unload(1'b1, 1'b0, 1);
        run_unload(1'b0, 1'b0, 2);

        // Spurious start mid-run, then reset mid-run, then a clean run.
        clear_mon();
        push_expected(1'b0, 1'b0);
        i_bank = 1'b0; i_bitrev = 1'b0; i_ready = 1'b1; i_start = 1'b1;
        start_cyc = cyc;
        step();
        for (int k = 1; k <= 6; k++) begin
            i_start = (k == 5);
            rst = (k == 6);
            if (k == 6) begin
                check("no_restart_addr", 32'(o_rd_addr), 32'd5);
                check("no_restart_busy", 32'(o_busy), 32'd1);
            end
            step();
        end
        rst = 1'b0;
        i_start = 1'b0;
        reset_check("midrun_reset");
        check("beats_before_reset", 32'(beats), 32'd4);
        run_unload(1'b0, 1'b0, 0);

        // Minimum length build.
        clear_mon();
        exp2_q.push_back('{re: ram2_re[0], im: ram2_im[0], idx: 32'd0});
        exp2_q.push_back('{re: ram2_re[1], im: ram2_im[1], idx: 32'd1});
        start2 = 1'b1; ready2 = 1'b1;
        start_cyc = cyc;
        step();
        for (int k = 1; k < 100 && done2_cnt == 0; k++) begin
            start2 = 1'b0;
            step();
        end
        if (done2_cnt == 0) check("n2_timeout_done", 32'd0, 32'd1);
        check("n2_beats", 32'(beats2), 32'd2);
        check("n2_first_cycle", 32'(first2_rel), 32'd3);
        check("n2_last_cycle", 32'(last2_rel), 32'd4);
        check("n2_done_cycle", 32'(done2_rel), 32'd5);
        check("n2_busy_after", 32'(busy2), 32'd0);
        check("n2_bank_sel", 32'(bank_sel2), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
